// File: rtl/alu_byte_sequencer_pkg.sv
// Shared ALU definitions: operation codes, sequencer state encoding and small helpers
// used by the alu, the byte sequencer and their benches.
package alu_byte_sequencer_pkg;

  localparam logic [2:0] ALU_OP_TEST        = 3'd0;
  localparam logic [2:0] ALU_OP_SUM         = 3'd1;
  localparam logic [2:0] ALU_OP_AND         = 3'd2;
  localparam logic [2:0] ALU_OP_OR          = 3'd3;
  localparam logic [2:0] ALU_OP_XOR         = 3'd4;
  localparam logic [2:0] ALU_OP_SHIFT_LEFT  = 3'd5;
  localparam logic [2:0] ALU_OP_SHIFT_RIGHT = 3'd6;
  localparam logic [2:0] ALU_OP_NOT         = 3'd7;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } seq_state_e;

  // Shifts cross byte boundaries, so the byte-serial sequencer cannot run them.
  function automatic logic is_shift_op(input logic [2:0] op);
    return (op == ALU_OP_SHIFT_LEFT) || (op == ALU_OP_SHIFT_RIGHT);
  endfunction

  function automatic logic is_sub_op(input logic [2:0] op, input logic sub);
    return (op == ALU_OP_SUM) && sub;
  endfunction

endpackage

// File: rtl/alu.sv
// 8-bit combinational alu driven byte-by-byte by alu_byte_sequencer.
module alu
  import alu_byte_sequencer_pkg::*;
(
  input  logic [7:0] operand_0,
  input  logic [7:0] operand_1,
  input  logic [2:0] operation,
  input  logic       carry_in,
  input  logic       invert_op_1,
  output logic [7:0] result,
  output logic       carry_out
);

  logic [7:0] op1_s;
  logic [8:0] sum_s;

  // Operand conditioning and adder for SUM/SUB.
  always_comb begin
    op1_s = invert_op_1 ? ~operand_1 : operand_1;
    sum_s = {1'b0, operand_0} + {1'b0, op1_s} + {8'd0, carry_in};
  end

  // Operation select; only SUM produces a carry.
  always_comb begin
    result    = 8'd0;
    carry_out = 1'b0;
    case (operation)
      ALU_OP_TEST:        result = 8'd0;
      ALU_OP_SUM: begin
        result    = sum_s[7:0];
        carry_out = sum_s[8];
      end
      ALU_OP_AND:         result = operand_0 & op1_s;
      ALU_OP_OR:          result = operand_0 | op1_s;
      ALU_OP_XOR:         result = operand_0 ^ op1_s;
      ALU_OP_SHIFT_LEFT:  result = {operand_0[6:0], 1'b0};
      ALU_OP_SHIFT_RIGHT: result = {1'b0, operand_0[7:1]};
      ALU_OP_NOT:         result = ~operand_0;
      default:            result = 8'd0;
    endcase
  end

endmodule

// File: rtl/alu_byte_sequencer.sv
// Runs one WIDTH-bit operation byte-serially (LSB first) on an external 8-bit alu,
// chaining carry for SUM/SUB and returning the assembled result with zero/carry flags.
module alu_byte_sequencer
  import alu_byte_sequencer_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic             req_sub,
  input  logic [WIDTH-1:0] req_a,
  input  logic [WIDTH-1:0] req_b,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic             rsp_carry,
  output logic             rsp_zero,
  output logic             rsp_err,
  output logic [7:0]       alu_operand_0,
  output logic [7:0]       alu_operand_1,
  output logic [2:0]       alu_operation,
  output logic             alu_carry_in,
  output logic             alu_invert_op_1,
  input  logic [7:0]       alu_result,
  input  logic             alu_carry_out
);

  localparam int NBYTES = WIDTH / 8;
  localparam int IDXW   = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  seq_state_e       state_r;
  logic [IDXW-1:0]  byte_idx_r;
  logic [2:0]       op_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [WIDTH-1:0] result_r;
  logic             carry_r;
  logic             err_r;

  logic [WIDTH-1:0] result_next_s;
  logic [IDXW-1:0]  next_idx_s;
  logic             last_byte_s;
  logic             carry_next_s;

  // Merge the current alu byte into the partial result and derive the next carry.
  always_comb begin
    result_next_s = result_r;
    result_next_s[{byte_idx_r, 3'b000} +: 8] = alu_result;
    next_idx_s   = byte_idx_r + IDXW'(1);
    last_byte_s  = (byte_idx_r == IDXW'(NBYTES - 1));
    carry_next_s = (op_r == ALU_OP_SUM) ? alu_carry_out : 1'b0;
  end

  // Sequencer FSM; all handshake and alu-side outputs are registered here.
  always_ff @(posedge clk) begin
    if (!nrst) begin
      state_r         <= IDLE;
      byte_idx_r      <= '0;
      op_r            <= ALU_OP_TEST;
      a_r             <= '0;
      b_r             <= '0;
      result_r        <= '0;
      carry_r         <= 1'b0;
      err_r           <= 1'b0;
      req_ready       <= 1'b1;
      rsp_valid       <= 1'b0;
      rsp_result      <= '0;
      rsp_carry       <= 1'b0;
      rsp_zero        <= 1'b0;
      rsp_err         <= 1'b0;
      alu_operand_0   <= 8'd0;
      alu_operand_1   <= 8'd0;
      alu_operation   <= ALU_OP_TEST;
      alu_carry_in    <= 1'b0;
      alu_invert_op_1 <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          if (req_valid) begin
            op_r       <= req_op;
            a_r        <= req_a;
            b_r        <= req_b;
            byte_idx_r <= '0;
            result_r   <= '0;
            carry_r    <= is_sub_op(req_op, req_sub);
            err_r      <= is_shift_op(req_op);
            req_ready  <= 1'b0;
            state_r    <= RUN;
            // Byte 0 is presented to the alu in the first RUN cycle.
            if (is_shift_op(req_op)) begin
              alu_operand_0   <= 8'd0;
              alu_operand_1   <= 8'd0;
              alu_operation   <= ALU_OP_TEST;
              alu_carry_in    <= 1'b0;
              alu_invert_op_1 <= 1'b0;
            end else begin
              alu_operand_0   <= req_a[7:0];
              alu_operand_1   <= req_b[7:0];
              alu_operation   <= req_op;
              alu_carry_in    <= is_sub_op(req_op, req_sub);
              alu_invert_op_1 <= is_sub_op(req_op, req_sub);
            end
          end
        end
        RUN: begin
          if (err_r) begin
            // Unsupported op: one idle cycle, then an error response with zeroed flags.
            state_r    <= DONE;
            rsp_valid  <= 1'b1;
            rsp_result <= '0;
            rsp_carry  <= 1'b0;
            rsp_zero   <= 1'b0;
            rsp_err    <= 1'b1;
          end else begin
            result_r   <= result_next_s;
            carry_r    <= carry_next_s;
            byte_idx_r <= next_idx_s;
            if (last_byte_s) begin
              state_r         <= DONE;
              rsp_valid       <= 1'b1;
              rsp_result      <= result_next_s;
              rsp_carry       <= carry_next_s;
              rsp_zero        <= ~|result_next_s;
              rsp_err         <= 1'b0;
              alu_operand_0   <= 8'd0;
              alu_operand_1   <= 8'd0;
              alu_operation   <= ALU_OP_TEST;
              alu_carry_in    <= 1'b0;
              alu_invert_op_1 <= 1'b0;
            end else begin
              alu_operand_0 <= a_r[{next_idx_s, 3'b000} +: 8];
              alu_operand_1 <= b_r[{next_idx_s, 3'b000} +: 8];
              alu_carry_in  <= carry_next_s;
            end
          end
        end
        DONE: begin
          if (rsp_ready) begin
            state_r   <= IDLE;
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state_r         <= IDLE;
          req_ready       <= 1'b1;
          rsp_valid       <= 1'b0;
          alu_operand_0   <= 8'd0;
          alu_operand_1   <= 8'd0;
          alu_operation   <= ALU_OP_TEST;
          alu_carry_in    <= 1'b0;
          alu_invert_op_1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_byte_sequencer.sv
// Self-checking bench: sequencer wired to the real alu, directed vector table,
// randomized transactions against a word-level reference model, and handshake/reset sequences.
module tb_alu_byte_sequencer;
  import alu_byte_sequencer_pkg::*;

  localparam int WIDTH = 32;

  logic             clk;
  logic             nrst;
  logic             req_valid;
  logic             req_ready;
  logic [2:0]       req_op;
  logic             req_sub;
  logic [WIDTH-1:0] req_a;
  logic [WIDTH-1:0] req_b;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [WIDTH-1:0] rsp_result;
  logic             rsp_carry;
  logic             rsp_zero;
  logic             rsp_err;
  logic [7:0]       alu_operand_0;
  logic [7:0]       alu_operand_1;
  logic [2:0]       alu_operation;
  logic             alu_carry_in;
  logic             alu_invert_op_1;
  logic [7:0]       alu_result;
  logic             alu_carry_out;

  int errors = 0;
  int checks = 0;

  alu_byte_sequencer #(.WIDTH(WIDTH)) dut (
    .clk(clk), .nrst(nrst),
    .req_valid(req_valid), .req_ready(req_ready), .req_op(req_op), .req_sub(req_sub),
    .req_a(req_a), .req_b(req_b),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_carry(rsp_carry), .rsp_zero(rsp_zero), .rsp_err(rsp_err),
    .alu_operand_0(alu_operand_0), .alu_operand_1(alu_operand_1),
    .alu_operation(alu_operation), .alu_carry_in(alu_carry_in),
    .alu_invert_op_1(alu_invert_op_1),
    .alu_result(alu_result), .alu_carry_out(alu_carry_out)
  );

  alu u_alu (
    .operand_0(alu_operand_0), .operand_1(alu_operand_1), .operation(alu_operation),
    .carry_in(alu_carry_in), .invert_op_1(alu_invert_op_1),
    .result(alu_result), .carry_out(alu_carry_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic        sub;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        err;
    int          lat;
  } vec_t;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        err;
  } model_t;

  // Word-level reference: what the whole operation means, independent of byte slicing.
  function automatic model_t ref_model(input logic [2:0] op, input logic sub,
                                       input logic [31:0] a, input logic [31:0] b);
    model_t m;
    logic [32:0] wide;
    m.result = 32'd0;
    m.carry  = 1'b0;
    m.err    = 1'b0;
    wide     = 33'd0;
    case (op)
      ALU_OP_SUM: begin
        if (sub) wide = {1'b0, a} + {1'b0, ~b} + 33'd1;
        else     wide = {1'b0, a} + {1'b0, b};
        m.result = wide[31:0];
        m.carry  = wide[32];
      end
      ALU_OP_AND: m.result = a & b;
      ALU_OP_OR:  m.result = a | b;
      ALU_OP_XOR: m.result = a ^ b;
      ALU_OP_NOT: m.result = ~a;
      ALU_OP_SHIFT_LEFT, ALU_OP_SHIFT_RIGHT: m.err = 1'b1;
      default: m.result = 32'd0;
    endcase
    m.zero = m.err ? 1'b0 : (m.result == 32'd0);
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Full request/response transaction including latency and per-byte alu drive checks.
  task automatic do_txn(input string name, input logic [2:0] op, input logic sub,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] e_res, input logic e_carry, input logic e_zero,
                        input logic e_err, input int e_lat);
    int w;
    int lat;
    logic inv;
    logic alu_ok;
    w = 0;
    while (!req_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    chk({name, " req_ready"}, {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_op = op; req_sub = sub; req_a = a; req_b = b;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk({name, " busy"}, {31'd0, req_ready}, 32'd0);
    inv = (op == ALU_OP_SUM) && sub;
    alu_ok = 1'b1;
    lat = 0;
    while (!rsp_valid && lat < 20) begin
      if (e_err || lat >= 4) begin
        if (alu_operation !== ALU_OP_TEST || alu_operand_0 !== 8'd0 ||
            alu_operand_1 !== 8'd0 || alu_carry_in !== 1'b0 || alu_invert_op_1 !== 1'b0)
          alu_ok = 1'b0;
      end else begin
        if (alu_operand_0 !== a[lat*8 +: 8] || alu_operand_1 !== b[lat*8 +: 8] ||
            alu_operation !== op || alu_invert_op_1 !== inv)
          alu_ok = 1'b0;
      end
      @(posedge clk); #1; lat++;
    end
    chk({name, " alu_drive"}, {31'd0, alu_ok}, 32'd1);
    chk({name, " latency"}, lat, e_lat);
    chk({name, " result"}, rsp_result, e_res);
    chk({name, " carry"}, {31'd0, rsp_carry}, {31'd0, e_carry});
    chk({name, " zero"}, {31'd0, rsp_zero}, {31'd0, e_zero});
    chk({name, " err"}, {31'd0, rsp_err}, {31'd0, e_err});
    chk({name, " alu_idle_done"}, {29'd0, alu_operation}, {29'd0, ALU_OP_TEST});
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk({name, " rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
  endtask

  vec_t vecs[$];
  logic [2:0] rand_ops[7] = '{ALU_OP_SUM, ALU_OP_AND, ALU_OP_OR, ALU_OP_XOR, ALU_OP_NOT,
                              ALU_OP_SHIFT_LEFT, ALU_OP_SHIFT_RIGHT};

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    model_t m;
    logic [2:0] op;
    logic sub;
    logic [31:0] a, b;
    logic stable;
    logic quiet;

    vecs.push_back('{ALU_OP_SUM, 1'b0, 32'h000000FF, 32'h00000001, 32'h00000100, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{ALU_OP_SUM, 1'b0, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b1, 1'b1, 1'b0, 4});
    vecs.push_back('{ALU_OP_SUM, 1'b1, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, 1'b0, 4});
    vecs.push_back('{ALU_OP_SUM, 1'b1, 32'h00000000, 32'h00000001, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{ALU_OP_XOR, 1'b0, 32'hAAAAAAAA, 32'hF0F0F0F0, 32'h5A5A5A5A, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{ALU_OP_AND, 1'b0, 32'hAAAAAAAA, 32'hF0F0F0F0, 32'hA0A0A0A0, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{ALU_OP_OR,  1'b0, 32'hAAAAAAAA, 32'hF0F0F0F0, 32'hFAFAFAFA, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{ALU_OP_AND, 1'b1, 32'hAAAAAAAA, 32'hF0F0F0F0, 32'hA0A0A0A0, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{ALU_OP_NOT, 1'b0, 32'h0F0F00FF, 32'h12345678, 32'hF0F0FF00, 1'b0, 1'b0, 1'b0, 4});
    vecs.push_back('{ALU_OP_SHIFT_LEFT,  1'b0, 32'h12345678, 32'h00000001, 32'h00000000, 1'b0, 1'b0, 1'b1, 1});
    vecs.push_back('{ALU_OP_SHIFT_RIGHT, 1'b1, 32'h80000000, 32'h00000003, 32'h00000000, 1'b0, 1'b0, 1'b1, 1});

    nrst = 1'b0; req_valid = 1'b0; req_op = ALU_OP_TEST; req_sub = 1'b0;
    req_a = 32'd0; req_b = 32'd0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 nrst = 1'b1;
    chk("reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset rsp_result", rsp_result, 32'd0);
    chk("reset alu_operation", {29'd0, alu_operation}, {29'd0, ALU_OP_TEST});
    chk("reset alu_operands", {16'd0, alu_operand_0, alu_operand_1}, 32'd0);

    foreach (vecs[i])
      do_txn($sformatf("vec%0d", i), vecs[i].op, vecs[i].sub, vecs[i].a, vecs[i].b,
             vecs[i].result, vecs[i].carry, vecs[i].zero, vecs[i].err, vecs[i].lat);

    for (int n = 0; n < 40; n++) begin
      op  = rand_ops[$urandom_range(0, 6)];
      sub = 1'($urandom_range(0, 1));
      a   = $urandom;
      b   = $urandom;
      if (n % 8 == 3) b = a;
      if (n % 8 == 5) a = 32'hFFFFFFFF;
      m = ref_model(op, sub, a, b);
      do_txn($sformatf("rand%0d", n), op, sub, a, b, m.result, m.carry, m.zero, m.err,
             m.err ? 1 : 4);
    end

    // Back-pressure: response must hold and new requests must be ignored while DONE.
    req_valid = 1'b1; req_op = ALU_OP_SUM; req_sub = 1'b0; req_a = 32'd1; req_b = 32'd2;
    @(posedge clk); #1;
    req_op = ALU_OP_XOR; req_a = 32'hDEADBEEF;
    for (int k = 0; k < 20 && !rsp_valid; k++) begin
      @(posedge clk); #1;
    end
    chk("hold rsp_valid", {31'd0, rsp_valid}, 32'd1);
    stable = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b1 || rsp_result !== 32'd3 || req_ready !== 1'b0 ||
          rsp_carry !== 1'b0 || rsp_zero !== 1'b0 || rsp_err !== 1'b0)
        stable = 1'b0;
    end
    chk("hold stable", {31'd0, stable}, 32'd1);
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("hold release", {30'd0, req_ready, rsp_valid}, 32'd2);

    // Reset during RUN discards the transaction.
    req_valid = 1'b1; req_op = ALU_OP_SUM; req_a = 32'h00000010; req_b = 32'h00000020;
    @(posedge clk); #1;
    req_valid = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b0;
    @(posedge clk); #1;
    nrst = 1'b1;
    chk("midrun reset req_ready", {31'd0, req_ready}, 32'd1);
    chk("midrun reset rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("midrun reset alu_idle", {21'd0, alu_operation, alu_operand_0}, 32'd0);
    quiet = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); #1;
      if (rsp_valid !== 1'b0 || req_ready !== 1'b1) quiet = 1'b0;
    end
    chk("midrun reset quiet", {31'd0, quiet}, 32'd1);
    do_txn("post_reset", ALU_OP_SUM, 1'b0, 32'h7FFFFFFF, 32'h00000001, 32'h80000000,
           1'b0, 1'b0, 1'b0, 4);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
